scan_decoder: RTL
=================

# scan_decoder

Registered, parametrised one-hot decoder that extends the plain 2-to-4 combinational decoder with a clocked output, a latched selection and an automatic scan mode. In direct mode it decodes a SEL_W-bit index to a 2**SEL_W one-hot output on a valid strobe. In scan mode it walks the active output across all channels with a programmable dwell time. It sits between control logic and per-channel strobes (row/column drive, mux select, chip-select fan-out).

## Interface
- SEL_W, 2, index width; output width OUT_W = 2**SEL_W (SEL_W in 1..6)
- HOLD_W, 4, dwell counter width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- enable  input  1  global enable; low forces outputs off
- mode  input  1  0 = direct decode, 1 = scan
- in  input  SEL_W  channel index (direct target / scan start)
- in_valid  input  1  strobe qualifying `in`
- hold  input  HOLD_W  dwell per channel in scan mode = hold+1 cycles
- out  output  OUT_W  registered one-hot (or all-zero) channel select
- idx  output  SEL_W  registered index of current channel
- wrap  output  1  one-cycle pulse when scan advances from OUT_W-1 to 0

## Operation
- One clock; reset is asynchronous and active-low.
- State machine: IDLE, DIRECT, SCAN (registered).
- Priority each cycle: rst_n low > enable low > mode/in_valid.
- enable low (any state): next edge -> IDLE, out=0, wrap=0; idx and dwell counter retain their values.
- IDLE, enable=1, mode=0: stays IDLE until in_valid=1; then -> DIRECT, idx<=in, out<=onehot(in).
- IDLE, enable=1, mode=1: -> SCAN, idx<=in, out<=onehot(in), cnt<=hold. in_valid is ignored.
- DIRECT: out constant until in_valid=1, then idx<=in, out<=onehot(in) next edge. Repeated equal `in` produces no change. mode=1 -> SCAN from current idx, cnt<=hold.
- SCAN: cnt!=0 -> cnt<=cnt-1. cnt==0 -> idx<=idx+1 (mod OUT_W), out<=onehot(idx+1), cnt<=hold (hold sampled at reload). wrap=1 on the same edge that idx goes OUT_W-1 -> 0, else 0.
- SCAN, mode=0: -> DIRECT. If in_valid=1 the same cycle, idx/out<=in; else the current idx/out are kept.
- hold=0: advance every cycle. Full period = OUT_W*(hold+1) cycles.
- out is always exactly one-hot in DIRECT/SCAN and all-zero in IDLE. It never shows two bits set, including on a mode switch.

## Timing
- Reset values: out=0, idx=0, wrap=0, cnt=0, state IDLE.
- Latency: in_valid sampled at edge N -> out valid after edge N (1 cycle). enable low at edge N -> out=0 after edge N.
- Deassertion of rst_n is synchronised externally. Reset mid-scan clears everything immediately, without waiting for an edge.
- Simultaneous mode=1 and in_valid=1 in DIRECT: the mode change wins and in is ignored.
- wrap is registered and aligned with out changing to bit 0.
- in_valid has no ready; every qualified cycle is accepted.

## Test plan
- Reset: rst_n=0 mid-scan with out=4'b0100 -> out=0, idx=0, wrap=0 asynchronously; IDLE after release.
- Direct (SEL_W=2): enable=1, mode=0, in_valid pulses with in=0,1,2,3 -> out=0001,0010,0100,1000, each one cycle after its strobe. enable=0 -> out=0000 next edge.
- Scan (SEL_W=2, hold=2): start in=2 -> out=0100 for 3 cycles, then 1000 for 3, then 0001 with wrap=1 for exactly that edge's cycle. Period 12 cycles.
- hold=0, SEL_W=3: out steps every cycle 0x01..0x80. wrap pulses every 8 cycles.
- Mode switch: in SCAN at idx=1, mode=0 with in_valid=1, in=3 -> out=1000 next edge, no intermediate value. Without in_valid, out stays 0010.
- Enable gap: in SCAN at idx=2, drop enable for 3 cycles -> out=0. Re-enable with mode=1, in=0 -> scan restarts at 0001 with cnt=hold.

Source files
------------

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with latched direct selection and an
// automatic scan mode that walks the active channel with a dwell time.
module scan_decoder #(
    parameter int SEL_W  = 2,
    parameter int HOLD_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        in,
    input  logic                    in_valid,
    input  logic [HOLD_W-1:0]       hold,
    output logic [(2**SEL_W)-1:0]   out,
    output logic [SEL_W-1:0]        idx,
    output logic                    wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam logic [SEL_W-1:0] LAST = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [SEL_W-1:0]   idx_n;
    logic [HOLD_W-1:0]  cnt, cnt_n;
    logic [OUT_W-1:0]   out_n;
    logic               wrap_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            out   <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            out   <= out_n;
            wrap  <= wrap_n;
        end
    end

    // idx and cnt deliberately survive an enable drop
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        if (!enable) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mode) begin
                        state_n = SCAN;
                        idx_n   = in;
                        cnt_n   = hold;
                    end else if (in_valid) begin
                        state_n = DIRECT;
                        idx_n   = in;
                    end
                end
                DIRECT: begin
                    if (mode) begin
                        state_n = SCAN;
                        cnt_n   = hold;
                    end else if (in_valid) begin
                        idx_n = in;
                    end
                end
                SCAN: begin
                    if (!mode) begin
                        state_n = DIRECT;
                        if (in_valid)
                            idx_n = in;
                    end else if (cnt == '0) begin
                        idx_n = idx + 1'b1;
                        cnt_n = hold;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // out is built from the next index only, so it is never two-hot
    always_comb begin
        out_n = '0;
        if (state_n != IDLE)
            out_n[idx_n] = 1'b1;
        wrap_n = enable && (state == SCAN) && mode
               && (cnt == '0) && (idx == LAST);
    end

endmodule
